mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 28 ++
 rtl/mem_arb_pick.sv | 27 ++
 rtl/mem_arbiter.sv | 172 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the two-port memory arbiter.
// The state enum, the requester port id and the fetch-word extraction helper live here.
package mem_arb_pkg;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 64;
    localparam int FETCH_W = 32;
    localparam int MASK_W  = DATA_W / 8;
    localparam int CNT_W   = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_RESP = 2'd2
    } state_e;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_D  = 1'b1
    } port_e;

    // A 64-bit memory beat carries two instruction words; address bit 2 selects the upper one.
    function automatic logic [FETCH_W-1:0] fetch_word(input logic [DATA_W-1:0] beat,
                                                      input logic              upper);
        return upper ? beat[DATA_W-1:FETCH_W] : beat[FETCH_W-1:0];
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between the fetch and data requesters.
// With MEM_ARB_RR_EN defined, simultaneous requests alternate; otherwise data always wins.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic  if_req,
    input  logic  d_req,
    input  port_e rr_ptr,
    output logic  any_req,
    output port_e winner,
    output port_e rr_ptr_next
);

    always_comb begin
        any_req     = if_req | d_req;
        winner      = d_req ? PORT_D : PORT_IF;
        rr_ptr_next = rr_ptr;
`ifdef MEM_ARB_RR_EN
        // rr_ptr names the port that wins the next tie; it flips to the loser after every grant.
        if (if_req && d_req) begin
            winner = rr_ptr;
        end
        rr_ptr_next = (winner == PORT_D) ? PORT_IF : PORT_D;
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a data port onto one memory port, one transaction at a time.
// Define MEM_ARB_RR_EN for round-robin tie breaking; the default build gives data fixed priority.
//
// state     | meaning
// IDLE      | nothing outstanding; grants the winner of any pending request
// ISSUE     | m_req asserted with latched fields, held until m_ready
// WAIT_RESP | read accepted by memory; waits for m_rvalid or the timeout
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [FETCH_W-1:0] if_rdata,
    output logic              if_err,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [MASK_W-1:0] d_wmask,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,

    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    output logic [MASK_W-1:0] m_wmask,
    input  logic              m_ready,
    input  logic              m_rvalid,
    input  logic [DATA_W-1:0] m_rdata
);

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    port_e             owner_q, rr_ptr_q, winner, rr_ptr_next;
    logic              any_req;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [MASK_W-1:0] wmask_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              take, store_done, resp_ok, timed_out;
    logic              fin_if, fin_d;

    mem_arb_pick u_pick (
        .if_req      (if_req),
        .d_req       (d_req),
        .rr_ptr      (rr_ptr_q),
        .any_req     (any_req),
        .winner      (winner),
        .rr_ptr_next (rr_ptr_next)
    );

    assign m_req   = (state_q == ISSUE);
    assign m_we    = we_q;
    assign m_addr  = addr_q;
    assign m_wdata = wdata_q;
    assign m_wmask = wmask_q;

    always_comb begin
        state_d    = state_q;
        take       = 1'b0;
        store_done = 1'b0;
        resp_ok    = 1'b0;
        timed_out  = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    take    = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (m_ready) begin
                    if (we_q) begin
                        store_done = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        state_d = WAIT_RESP;
                    end
                end
            end
            WAIT_RESP: begin
                // A response arriving on the last allowed cycle still beats the timeout.
                if (m_rvalid) begin
                    resp_ok = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q == TO_LAST) begin
                    timed_out = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign fin_if = (resp_ok | timed_out) && (owner_q == PORT_IF);
    assign fin_d  = (resp_ok | timed_out) && (owner_q == PORT_D);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            owner_q  <= PORT_D;
            rr_ptr_q <= PORT_D;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wmask_q  <= '0;
            cnt_q    <= '0;
        end else begin
            state_q <= state_d;
            if (take) begin
                owner_q  <= winner;
                rr_ptr_q <= rr_ptr_next;
                if (winner == PORT_D) begin
                    we_q    <= d_we;
                    addr_q  <= d_addr;
                    wdata_q <= d_wdata;
                    wmask_q <= d_wmask;
                end else begin
                    we_q    <= 1'b0;
                    addr_q  <= if_addr;
                    wdata_q <= '0;
                    wmask_q <= '0;
                end
            end
            if (state_q == WAIT_RESP) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else begin
                cnt_q <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if_gnt    <= 1'b0;
            d_gnt     <= 1'b0;
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            if_err    <= 1'b0;
            d_err     <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            if_gnt    <= take && (winner == PORT_IF);
            d_gnt     <= take && (winner == PORT_D);
            if_rvalid <= fin_if;
            d_rvalid  <= fin_d || store_done;
            if_err    <= fin_if && timed_out;
            d_err     <= fin_d && timed_out;
            if (fin_if) begin
                if_rdata <= timed_out ? '0 : fetch_word(m_rdata, addr_q[2]);
            end
            if (fin_d) begin
                d_rdata <= timed_out ? '0 : m_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations, then random traffic
// checked every cycle against a transaction-level model built from timestamps.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int TIMEOUT = 16;
`ifdef MEM_ARB_RR_EN
    localparam bit         RR        = 1'b1;
    localparam logic [3:0] EXP_ORDER = 4'b1010;
`else
    localparam bit         RR        = 1'b0;
    localparam logic [3:0] EXP_ORDER = 4'b1100;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_gnt, if_rvalid, if_err;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid, d_err;
    logic [31:0] d_addr;
    logic [63:0] d_wdata, d_rdata;
    logic [7:0]  d_wmask;
    logic        m_req, m_we, m_ready, m_rvalid;
    logic [31:0] m_addr;
    logic [63:0] m_wdata, m_rdata;
    logic [7:0]  m_wmask;

    mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_wmask(m_wmask),
        .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, got, exp);
    endtask

    // Model: one outstanding transaction described by its owner, fields and acceptance time.
    bit          armed = 1'b0;
    bit          m_act = 1'b0;
    int          acc_at = -1;
    port_e       t_port = PORT_D;
    port_e       ptr = PORT_D;
    port_e       w;
    bit          t_we;
    logic [31:0] t_addr;
    logic [63:0] t_wdata;
    logic [7:0]  t_wmask;
    bit          e_if_gnt, e_d_gnt, e_if_rv, e_d_rv, e_if_err, e_d_err, e_d_store;
    logic [31:0] e_if_rdata;
    logic [63:0] e_d_rdata;

    always @(negedge clk) begin
        if (armed) begin
            chk("if_gnt", 64'(if_gnt), 64'(e_if_gnt));
            chk("d_gnt", 64'(d_gnt), 64'(e_d_gnt));
            chk("if_rvalid", 64'(if_rvalid), 64'(e_if_rv));
            chk("d_rvalid", 64'(d_rvalid), 64'(e_d_rv));
            chk("m_req", 64'(m_req), 64'(m_act && acc_at < 0));
            if (m_act && acc_at < 0) begin
                chk("m_addr", 64'(m_addr), 64'(t_addr));
                chk("m_we", 64'(m_we), 64'(t_we));
                if (t_port == PORT_D) begin
                    chk("m_wdata", m_wdata, t_wdata);
                    chk("m_wmask", 64'(m_wmask), 64'(t_wmask));
                end
            end
            if (e_if_rv) begin
                chk("if_err", 64'(if_err), 64'(e_if_err));
                chk("if_rdata", 64'(if_rdata), 64'(e_if_rdata));
            end
            if (e_d_rv) begin
                chk("d_err", 64'(d_err), 64'(e_d_err));
                if (!e_d_store) chk("d_rdata", d_rdata, e_d_rdata);
            end
        end
        {e_if_gnt, e_d_gnt, e_if_rv, e_d_rv, e_if_err, e_d_err, e_d_store} = '0;
        if (rst) begin
            m_act  = 1'b0;
            acc_at = -1;
            ptr    = PORT_D;
            armed  = 1'b1;
        end else if (m_act && acc_at < 0) begin
            if (m_ready) begin
                if (t_we) begin
                    e_d_rv    = 1'b1;
                    e_d_err   = 1'b0;
                    e_d_store = 1'b1;
                    m_act     = 1'b0;
                end else begin
                    acc_at = cyc;
                end
            end
        end else if (m_act) begin
            // Read waits cycles acc_at+1 .. acc_at+TIMEOUT; a response on the last one still counts.
            if (m_rvalid || (cyc - acc_at == TIMEOUT)) begin
                if (t_port == PORT_IF) begin
                    e_if_rv    = 1'b1;
                    e_if_err   = !m_rvalid;
                    e_if_rdata = !m_rvalid ? 32'h0 : (t_addr[2] ? m_rdata[63:32] : m_rdata[31:0]);
                end else begin
                    e_d_rv    = 1'b1;
                    e_d_err   = !m_rvalid;
                    e_d_rdata = !m_rvalid ? 64'h0 : m_rdata;
                end
                m_act  = 1'b0;
                acc_at = -1;
            end
        end else if (if_req || d_req) begin
            if (if_req && d_req) w = RR ? ptr : PORT_D;
            else                 w = d_req ? PORT_D : PORT_IF;
            ptr     = (w == PORT_D) ? PORT_IF : PORT_D;
            t_port  = w;
            e_d_gnt = (w == PORT_D);
            e_if_gnt = (w == PORT_IF);
            t_we    = (w == PORT_D) ? d_we : 1'b0;
            t_addr  = (w == PORT_D) ? d_addr : if_addr;
            t_wdata = d_wdata;
            t_wmask = d_wmask;
            m_act   = 1'b1;
            acc_at  = -1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0] code;
        int         ng, ri, rd, n;
        bit         slow;

        rst = 1'b1;
        if_req = 0; if_addr = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_wmask = 0;
        m_ready = 0; m_rvalid = 0; m_rdata = 0;
        step(); step();
        chk("rst_pulses", 64'({if_gnt, d_gnt, if_rvalid, d_rvalid, if_err, d_err, m_req, m_we}), 64'h0);
        chk("rst_m_addr", 64'(m_addr), 64'h0);
        chk("rst_m_wdata", m_wdata, 64'h0);
        chk("rst_m_wmask", 64'(m_wmask), 64'h0);
        chk("rst_if_rdata", 64'(if_rdata), 64'h0);
        chk("rst_d_rdata", d_rdata, 64'h0);
        rst = 1'b0;

        // Single fetch, best-case latency: rvalid three cycles after the request.
        m_ready = 1;
        if_req = 1; if_addr = 32'h4;
        step();
        chk("fetch_gnt", 64'(if_gnt), 64'h1);
        chk("fetch_m_addr", 64'(m_addr), 64'h4);
        if_req = 0;
        step();
        m_rvalid = 1; m_rdata = 64'hAAAA_BBBB_0000_0013;
        step();
        m_rvalid = 0;
        chk("fetch_rvalid", 64'(if_rvalid), 64'h1);
        chk("fetch_rdata", 64'(if_rdata), 64'hAAAABBBB);
        chk("fetch_err", 64'(if_err), 64'h0);

        // Store held off by m_ready for three cycles.
        m_ready = 0;
        d_req = 1; d_we = 1; d_addr = 32'h10; d_wdata = 64'h1122_3344_5566_7788; d_wmask = 8'h0F;
        step();
        chk("store_gnt", 64'(d_gnt), 64'h1);
        d_req = 0;
        for (int i = 0; i < 4; i++) begin
            chk("store_m_req", 64'(m_req), 64'h1);
            chk("store_m_addr", 64'(m_addr), 64'h10);
            chk("store_m_wmask", 64'(m_wmask), 64'h0F);
            chk("store_m_we", 64'(m_we), 64'h1);
            if (i == 3) m_ready = 1;
            step();
        end
        chk("store_rvalid", 64'(d_rvalid), 64'h1);
        chk("store_err", 64'(d_err), 64'h0);
        d_we = 0;

        // Simultaneous requests, two each, starting from a fresh reset.
        rst = 1; step(); rst = 0;
        m_ready = 1; m_rvalid = 1;
        ri = 2; rd = 2; code = '0; ng = 0;
        if_req = 1; if_addr = 32'h100;
        d_req = 1; d_we = 0; d_addr = 32'h200;
        for (int i = 0; i < 60 && (ri > 0 || rd > 0); i++) begin
            step();
            if (if_gnt) begin code = {code[2:0], 1'b0}; ng++; ri--; if_req = (ri > 0); end
            if (d_gnt)  begin code = {code[2:0], 1'b1}; ng++; rd--; d_req = (rd > 0); end
        end
        chk("grant_count", 64'(ng), 64'd4);
        chk("grant_order", 64'(code), 64'(EXP_ORDER));
        step(); step(); step();
        m_rvalid = 0;

        // Load with no response: error 16 cycles after entering WAIT_RESP, late response ignored.
        d_req = 1; d_we = 0; d_addr = 32'h40;
        step();
        chk("to_gnt", 64'(d_gnt), 64'h1);
        d_req = 0;
        n = 0;
        while (!d_rvalid && n < 40) begin step(); n++; end
        chk("to_latency", 64'(n), 64'(TIMEOUT + 1));
        chk("to_err", 64'(d_err), 64'h1);
        chk("to_rdata", d_rdata, 64'h0);
        m_rvalid = 1; m_rdata = 64'hDEAD_BEEF_CAFE_F00D;
        step();
        m_rvalid = 0;
        for (int i = 0; i < 3; i++) begin
            chk("late_rvalid", 64'({if_rvalid, d_rvalid}), 64'h0);
            step();
        end

        // Reset during WAIT_RESP, then a stale response, then a normal fetch.
        if_req = 1; if_addr = 32'h8;
        step();
        chk("rw_gnt", 64'(if_gnt), 64'h1);
        if_req = 0;
        step();
        rst = 1;
        step();
        rst = 0; m_rvalid = 1; m_rdata = 64'h5555_6666_7777_8888;
        chk("rw_no_rvalid0", 64'({if_rvalid, d_rvalid}), 64'h0);
        step();
        m_rvalid = 0;
        chk("rw_no_rvalid1", 64'({if_rvalid, d_rvalid}), 64'h0);
        step();
        chk("rw_no_rvalid2", 64'({if_rvalid, d_rvalid}), 64'h0);
        if_req = 1; if_addr = 32'hC;
        step();
        chk("post_rst_gnt", 64'(if_gnt), 64'h1);
        if_req = 0;
        step();
        m_rvalid = 1; m_rdata = 64'h1234_5678_9ABC_DEF0;
        step();
        m_rvalid = 0;
        chk("post_rst_rvalid", 64'(if_rvalid), 64'h1);
        chk("post_rst_rdata", 64'(if_rdata), 64'h12345678);

        // Random traffic, checked by the per-cycle model.
        slow = 0;
        for (int c = 0; c < 4000; c++) begin
            if (c % 250 == 0) slow = ($urandom_range(1) == 1);
            rst = ($urandom_range(599) == 0);
            if (if_req && if_gnt) if_req = 0;
            else if (!if_req && $urandom_range(2) == 0) begin
                if_req  = 1;
                if_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (d_req && d_gnt) d_req = 0;
            else if (!d_req && $urandom_range(2) == 0) begin
                d_req   = 1;
                d_we    = ($urandom_range(1) == 1);
                d_addr  = $urandom & 32'hFFFF_FFF8;
                d_wdata = {$urandom, $urandom};
                d_wmask = 8'($urandom);
            end
            m_ready = ($urandom_range(2) == 0);
            m_rdata = {$urandom, $urandom};
            if (m_act && acc_at >= 0)
                m_rvalid = slow ? ($urandom_range(39) == 0) : ($urandom_range(3) == 0);
            else
                m_rvalid = ($urandom_range(7) == 0);
            step();
        end
        rst = 0; if_req = 0; d_req = 0; m_rvalid = 0; m_ready = 1;
        repeat (24) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
